// File: rtl/ifid_stage_ctrl.sv
// IF/ID pipeline latch with a one-entry skid buffer.
// Executes the hazard unit's bubble and squash requests and drives the ID/EX load and instruction.
module ifid_stage_ctrl #(
  parameter int unsigned       WIDTH = 16,
  parameter logic [WIDTH-1:0] NOP   = 16'h0000,
  parameter int unsigned       CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fetch_valid,
  output logic             fetch_ready,
  input  logic [WIDTH-1:0] fetch_ir,
  input  logic [WIDTH-1:0] fetch_pc,
  input  logic             gen_bubble,
  input  logic             squash_ID,
  input  logic             stall,
  output logic [WIDTH-1:0] IF_ID_ir,
  output logic [WIDTH-1:0] IF_ID_pc,
  output logic             IF_ID_valid,
  output logic             id_ex_load,
  output logic [WIDTH-1:0] id_ex_ir,
  output logic [CNT_W-1:0] bubble_count
);

  typedef enum logic [1:0] {StEmpty, StFull, StSkid} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] out_ir_q, out_pc_q;
  logic [WIDTH-1:0] skid_ir_q, skid_pc_q;
  logic [CNT_W-1:0] bubble_count_q;

  logic accept;
  logic hold;
  logic advance;

  // Ready depends on state alone so the fetch side sees no combinational path from hazards.
  assign fetch_ready = (state_q != StSkid);
  assign accept      = fetch_valid & fetch_ready;
  assign hold        = stall | gen_bubble;
  assign advance     = (state_q != StEmpty) & ~squash_ID & ~hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StEmpty;
      out_ir_q       <= NOP;
      out_pc_q       <= '0;
      skid_ir_q      <= NOP;
      skid_pc_q      <= '0;
      bubble_count_q <= '0;
    end else if (squash_ID) begin
      // Squash wins over stall; a word accepted this cycle is dropped with the rest.
      state_q   <= StEmpty;
      out_ir_q  <= NOP;
      out_pc_q  <= '0;
      skid_ir_q <= NOP;
      skid_pc_q <= '0;
    end else begin
      if (gen_bubble && !stall && (bubble_count_q != '1)) begin
        bubble_count_q <= bubble_count_q + CNT_W'(1);
      end
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            state_q  <= StFull;
            out_ir_q <= fetch_ir;
            out_pc_q <= fetch_pc;
          end
        end
        StFull: begin
          if (!hold) begin
            if (accept) begin
              out_ir_q <= fetch_ir;
              out_pc_q <= fetch_pc;
            end else begin
              state_q <= StEmpty;
            end
          end else if (accept) begin
            state_q   <= StSkid;
            skid_ir_q <= fetch_ir;
            skid_pc_q <= fetch_pc;
          end
        end
        StSkid: begin
          if (!hold) begin
            state_q  <= StFull;
            out_ir_q <= skid_ir_q;
            out_pc_q <= skid_pc_q;
          end
        end
        default: state_q <= StEmpty;
      endcase
    end
  end

  assign IF_ID_valid  = (state_q != StEmpty);
  assign IF_ID_ir     = IF_ID_valid ? out_ir_q : NOP;
  assign IF_ID_pc     = out_pc_q;
  assign bubble_count = bubble_count_q;

  // Squash still loads ID/EX (with a NOP) even under a downstream stall.
  assign id_ex_load = rst_n & (squash_ID | ~stall);
  assign id_ex_ir   = advance ? out_ir_q : NOP;

endmodule

// File: tb/tb_ifid_stage_ctrl.sv
// Bench for ifid_stage_ctrl: directed vector table, hand sequences and a random run
// checked against a queue-based model of the latch.
module tb_ifid_stage_ctrl;

  localparam logic [15:0] NOP = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [15:0] fetch_ir, fetch_pc;
  logic        gen_bubble, squash_ID, stall;
  logic [15:0] IF_ID_ir, IF_ID_pc;
  logic        IF_ID_valid;
  logic        id_ex_load;
  logic [15:0] id_ex_ir;
  logic [15:0] bubble_count;

  logic        fetch_ready2;
  logic [15:0] IF_ID_ir2, IF_ID_pc2, id_ex_ir2;
  logic        IF_ID_valid2, id_ex_load2;
  logic [1:0]  bubble_count2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ifid_stage_ctrl #(.WIDTH(16), .NOP(16'h0000), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_ir(fetch_ir), .fetch_pc(fetch_pc), .gen_bubble(gen_bubble), .squash_ID(squash_ID),
    .stall(stall), .IF_ID_ir(IF_ID_ir), .IF_ID_pc(IF_ID_pc), .IF_ID_valid(IF_ID_valid),
    .id_ex_load(id_ex_load), .id_ex_ir(id_ex_ir), .bubble_count(bubble_count)
  );

  ifid_stage_ctrl #(.WIDTH(16), .NOP(16'h0000), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready2),
    .fetch_ir(fetch_ir), .fetch_pc(fetch_pc), .gen_bubble(gen_bubble), .squash_ID(squash_ID),
    .stall(stall), .IF_ID_ir(IF_ID_ir2), .IF_ID_pc(IF_ID_pc2), .IF_ID_valid(IF_ID_valid2),
    .id_ex_load(id_ex_load2), .id_ex_ir(id_ex_ir2), .bubble_count(bubble_count2)
  );

  // Reference model: the latch is a FIFO of at most two words.
  typedef struct {
    logic [15:0] ir;
    logic [15:0] pc;
  } word_t;
  word_t       mq[$];
  int unsigned mcnt16 = 0;
  int unsigned mcnt2  = 0;

  typedef struct {
    logic        fv;
    logic [15:0] ir;
    logic [15:0] pc;
    logic        bub, sq, st;
    logic        e_ready, e_valid;
    logic [15:0] e_ifid;
    logic        e_load;
    logic [15:0] e_idex;
    int          e_cnt;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(logic fv, logic [15:0] ir, logic [15:0] pc, logic bub, logic sq,
                              logic st, logic e_ready, logic e_valid, logic [15:0] e_ifid,
                              logic e_load, logic [15:0] e_idex, int e_cnt);
    vec_t v;
    v.fv = fv; v.ir = ir; v.pc = pc; v.bub = bub; v.sq = sq; v.st = st;
    v.e_ready = e_ready; v.e_valid = e_valid; v.e_ifid = e_ifid;
    v.e_load = e_load; v.e_idex = e_idex; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic fv, input logic [15:0] ir, input logic [15:0] pc,
                       input logic bub, input logic sq, input logic st);
    fetch_valid = fv; fetch_ir = ir; fetch_pc = pc;
    gen_bubble = bub; squash_ID = sq; stall = st;
  endtask

  task automatic model_check();
    logic        e_load;
    logic [15:0] e_idex;
    chk1("m_fetch_ready", fetch_ready, mq.size() < 2);
    chk1("m_IF_ID_valid", IF_ID_valid, mq.size() != 0);
    chk16("m_IF_ID_ir", IF_ID_ir, (mq.size() != 0) ? mq[0].ir : NOP);
    if (mq.size() != 0) chk16("m_IF_ID_pc", IF_ID_pc, mq[0].pc);
    e_load = squash_ID | ~stall;
    e_idex = (!squash_ID && !stall && !gen_bubble && mq.size() != 0) ? mq[0].ir : NOP;
    chk1("m_id_ex_load", id_ex_load, e_load);
    if (e_load) chk16("m_id_ex_ir", id_ex_ir, e_idex);
    chk16("m_bubble_count", bubble_count, 16'(mcnt16));
    chk16("m_bubble_count_w2", {14'd0, bubble_count2}, 16'(mcnt2));
  endtask

  task automatic model_clock();
    bit acc;
    acc = fetch_valid && (mq.size() < 2);
    if (squash_ID) begin
      mq.delete();
    end else begin
      if (!stall && gen_bubble) begin
        if (mcnt16 < 65535) mcnt16++;
        if (mcnt2 < 3) mcnt2++;
      end
      if (!stall && !gen_bubble && mq.size() != 0) void'(mq.pop_front());
      if (acc) mq.push_back('{fetch_ir, fetch_pc});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic step(input logic fv, input logic [15:0] ir, input logic [15:0] pc,
                      input logic bub, input logic sq, input logic st);
    drive(fv, ir, pc, bub, sq, st);
    #1;
    model_check();
    tick();
  endtask

  task automatic model_reset();
    mq.delete();
    mcnt16 = 0;
    mcnt2  = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    model_reset();
    @(negedge clk);
    #1;
    chk1("rst_fetch_ready", fetch_ready, 1'b1);
    chk1("rst_IF_ID_valid", IF_ID_valid, 1'b0);
    chk16("rst_IF_ID_ir", IF_ID_ir, NOP);
    chk16("rst_IF_ID_pc", IF_ID_pc, 16'h0000);
    chk1("rst_id_ex_load", id_ex_load, 1'b0);
    chk16("rst_id_ex_ir", id_ex_ir, NOP);
    chk16("rst_bubble_count", bubble_count, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    //            fv  ir        pc       bub sq st | rdy vld ifid     ld idex     cnt
    vecs.push_back(mk(1, 16'h1111, 16'h0100, 0, 0, 0, 1, 0, 16'h0000, 1, 16'h0000, 0));
    vecs.push_back(mk(1, 16'h2222, 16'h0102, 0, 0, 0, 1, 1, 16'h1111, 1, 16'h1111, 0));
    vecs.push_back(mk(1, 16'h3333, 16'h0104, 0, 0, 0, 1, 1, 16'h2222, 1, 16'h2222, 0));
    vecs.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 0, 1, 1, 16'h3333, 1, 16'h3333, 0));
    vecs.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 0, 1, 0, 16'h0000, 1, 16'h0000, 0));
    vecs.push_back(mk(1, 16'h4444, 16'h0200, 0, 0, 0, 1, 0, 16'h0000, 1, 16'h0000, 0));
    vecs.push_back(mk(1, 16'h5555, 16'h0202, 1, 0, 0, 1, 1, 16'h4444, 1, 16'h0000, 0));
    vecs.push_back(mk(1, 16'h6666, 16'h0204, 1, 0, 0, 0, 1, 16'h4444, 1, 16'h0000, 1));
    vecs.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 0, 0, 1, 16'h4444, 1, 16'h4444, 2));
    vecs.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 0, 1, 1, 16'h5555, 1, 16'h5555, 2));
    vecs.push_back(mk(1, 16'h7777, 16'h0300, 1, 0, 0, 1, 0, 16'h0000, 1, 16'h0000, 2));
    vecs.push_back(mk(1, 16'h8888, 16'h0302, 0, 0, 1, 1, 1, 16'h7777, 0, 16'h0000, 3));
    vecs.push_back(mk(1, 16'h9999, 16'h0304, 0, 1, 0, 0, 1, 16'h7777, 1, 16'h0000, 3));
    vecs.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 0, 1, 0, 16'h0000, 1, 16'h0000, 3));
    vecs.push_back(mk(1, 16'haaaa, 16'h0400, 0, 0, 0, 1, 0, 16'h0000, 1, 16'h0000, 3));
    vecs.push_back(mk(1, 16'hbbbb, 16'h0402, 0, 1, 0, 1, 1, 16'haaaa, 1, 16'h0000, 3));
    vecs.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 0, 1, 0, 16'h0000, 1, 16'h0000, 3));
    vecs.push_back(mk(1, 16'hcccc, 16'h0500, 0, 0, 0, 1, 0, 16'h0000, 1, 16'h0000, 3));
    vecs.push_back(mk(0, 16'h0000, 16'h0000, 1, 0, 1, 1, 1, 16'hcccc, 0, 16'h0000, 3));
    vecs.push_back(mk(0, 16'h0000, 16'h0000, 1, 0, 1, 1, 1, 16'hcccc, 0, 16'h0000, 3));
    vecs.push_back(mk(0, 16'h0000, 16'h0000, 1, 0, 1, 1, 1, 16'hcccc, 0, 16'h0000, 3));
    vecs.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 0, 1, 1, 16'hcccc, 1, 16'hcccc, 3));
    vecs.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 0, 1, 0, 16'h0000, 1, 16'h0000, 3));
    vecs.push_back(mk(0, 16'h0000, 16'h0000, 1, 0, 0, 1, 0, 16'h0000, 1, 16'h0000, 3));
    vecs.push_back(mk(0, 16'h0000, 16'h0000, 1, 0, 0, 1, 0, 16'h0000, 1, 16'h0000, 4));
    vecs.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 0, 1, 0, 16'h0000, 1, 16'h0000, 5));

    foreach (vecs[i]) begin
      drive(vecs[i].fv, vecs[i].ir, vecs[i].pc, vecs[i].bub, vecs[i].sq, vecs[i].st);
      #1;
      chk1($sformatf("v%0d_fetch_ready", i), fetch_ready, vecs[i].e_ready);
      chk1($sformatf("v%0d_IF_ID_valid", i), IF_ID_valid, vecs[i].e_valid);
      chk16($sformatf("v%0d_IF_ID_ir", i), IF_ID_ir, vecs[i].e_ifid);
      chk1($sformatf("v%0d_id_ex_load", i), id_ex_load, vecs[i].e_load);
      if (vecs[i].e_load) chk16($sformatf("v%0d_id_ex_ir", i), id_ex_ir, vecs[i].e_idex);
      chk16($sformatf("v%0d_bubble_count", i), bubble_count, 16'(vecs[i].e_cnt));
      model_check();
      tick();
    end
    chk16("sat_w2", {14'd0, bubble_count2}, 16'd3);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(99) < 70), 16'($urandom), 16'($urandom),
           1'($urandom_range(99) < 25), 1'($urandom_range(99) < 8),
           1'($urandom_range(99) < 20));
    end

    // Reset asserted between clock edges while both entries are occupied.
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 16'hd00d, 16'h0600, 1'b0, 1'b0, 1'b1);
    step(1'b1, 16'he00e, 16'h0602, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    #1;
    chk1("pre_rst_fetch_ready", fetch_ready, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk1("mid_rst_fetch_ready", fetch_ready, 1'b1);
    chk1("mid_rst_IF_ID_valid", IF_ID_valid, 1'b0);
    chk16("mid_rst_IF_ID_ir", IF_ID_ir, NOP);
    chk1("mid_rst_id_ex_load", id_ex_load, 1'b0);
    chk16("mid_rst_id_ex_ir", id_ex_ir, NOP);
    chk16("mid_rst_bubble_count", bubble_count, 16'h0000);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk1("post_rst_fetch_ready", fetch_ready, 1'b1);
    chk16("post_rst_IF_ID_ir", IF_ID_ir, 16'h0000);
    @(negedge clk);
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'hf00f, 16'h0700, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end (total=%0d bad=%0d)", total, bad);
    $fatal(1, "timeout");
  end

endmodule
